// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the M-stage memory access unit: instruction field
// positions, the store opcode and the store-data forward-select codes.
package mem_access_unit_pkg;

    // Instruction word field ranges
    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;

    // Opcode of a word store (sw)
    localparam logic [5:0] OP_SW = 6'b101011;

    // Store-data forward select codes; any code other than FWD_WD takes RTM
    typedef enum logic [2:0] {
        FWD_RD = 3'd0,
        FWD_WD = 3'd1
    } fwd_sel_e;

    // Extract the primary opcode field of an instruction word
    function automatic logic [5:0] get_opcode(input logic [31:0] ir);
        return ir[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/mem_access_unit_data_mem.sv
// Word-wide data memory: asynchronous read, synchronous whole-word write,
// synchronous active-low clear of every word (clear beats a pending write).
module data_mem
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Din,
    input  logic              We,
    output logic [31:0]       Dout
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Zero at time zero so reads before the first reset are defined
    logic [31:0] mem [Depth] = '{default: '0};

    // Clear all words while Reset is low, otherwise perform the store
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (We) begin
            mem[Addr] <= Din;
        end
    end

    // Asynchronous read returns the pre-edge word during a same-word write
    always_comb begin
        Dout = mem[Addr];
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access: sw decode, store-data forwarding and data memory.
// Optional macro MEM_WRITE_TRACE_EN prints one line per performed write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRM,
    input  logic [31:0] PC4M,
    input  logic [31:0] AOM,
    input  logic [31:0] RTM,
    input  logic [31:0] MUX_RF_WD_OUT,
    input  logic [2:0]  Forward_RT_M_Sel,
    output logic        MemWrite,
    output logic [31:0] MF_RT_M_OUT,
    output logic [31:0] Dout
);

    logic [ADDR_W-1:0] word_addr;

    // Byte address to word index; low two bits and high bits are dropped
    assign word_addr = AOM[ADDR_W+1:2];

    // Decode store enable and select forwarded store data
    always_comb begin
        MemWrite    = (get_opcode(IRM) == OP_SW);
        MF_RT_M_OUT = RTM;
        if (Forward_RT_M_Sel == FWD_WD) begin
            MF_RT_M_OUT = MUX_RF_WD_OUT;
        end
    end

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (word_addr),
        .Din   (MF_RT_M_OUT),
        .We    (MemWrite),
        .Dout  (Dout)
    );

`ifdef MEM_WRITE_TRACE_EN
    // Trace each write that actually lands in memory
    always_ff @(posedge Clk) begin
        if (Reset && MemWrite) begin
            $display("%d@%h: *%h <= %h", $time, PC4M - 32'd4, AOM, MF_RT_M_OUT);
        end
    end
`endif

    // Bits that intentionally take no part in the datapath
    logic unused_bits;
    assign unused_bits = ^{PC4M, IRM[OPCODE_LO-1:0], AOM[31:ADDR_W+2], AOM[1:0]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] IRM;
    logic [31:0] PC4M;
    logic [31:0] AOM;
    logic [31:0] RTM;
    logic [31:0] MUX_RF_WD_OUT;
    logic [2:0]  Forward_RT_M_Sel;
    logic        MemWrite;
    logic [31:0] MF_RT_M_OUT;
    logic [31:0] Dout;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IR_SW  = 32'hAC00_0000;
    localparam logic [31:0] IR_LW  = 32'h8C00_0000;
    localparam logic [31:0] IR_NOP = 32'h0000_0000;

    mem_access_unit #(
        .ADDR_W (10)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IRM              (IRM),
        .PC4M             (PC4M),
        .AOM              (AOM),
        .RTM              (RTM),
        .MUX_RF_WD_OUT    (MUX_RF_WD_OUT),
        .Forward_RT_M_Sel (Forward_RT_M_Sel),
        .MemWrite         (MemWrite),
        .MF_RT_M_OUT      (MF_RT_M_OUT),
        .Dout             (Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Read a word with a nop in M so no write occurs
    task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        IRM = IR_NOP;
        AOM = addr;
        #1;
        chk(tag, Dout, exp);
    endtask

    initial begin
        Reset            = 1'b0;
        IRM              = IR_NOP;
        PC4M             = 32'h0000_3004;
        AOM              = '0;
        RTM              = '0;
        MUX_RF_WD_OUT    = '0;
        Forward_RT_M_Sel = 3'd0;
        tick();
        Reset = 1'b1;

        // Reset state
        read_word("reset_w4", 32'h10, 32'h0);
        chk("nop_memwrite", {31'b0, MemWrite}, 32'h0);

        // sw, sel=0 -> word 4; old value visible before the edge
        IRM = IR_SW; AOM = 32'h10; RTM = 32'h1234_5678; Forward_RT_M_Sel = 3'd0;
        #1;
        chk("sw_memwrite", {31'b0, MemWrite}, 32'h1);
        chk("sel0_data", MF_RT_M_OUT, 32'h1234_5678);
        chk("sw_pre_edge", Dout, 32'h0);
        tick();
        chk("sw_post_edge", Dout, 32'h1234_5678);

        // Forwarded store data to word 8, then other select codes
        IRM = IR_SW; AOM = 32'h20; RTM = 32'h1; MUX_RF_WD_OUT = 32'hDEAD_BEEF;
        Forward_RT_M_Sel = 3'd1;
        #1;
        chk("sel1_data", MF_RT_M_OUT, 32'hDEAD_BEEF);
        tick();
        Forward_RT_M_Sel = 3'd5; #1;
        chk("sel5_data", MF_RT_M_OUT, 32'h1);
        Forward_RT_M_Sel = 3'd7; #1;
        chk("sel7_data", MF_RT_M_OUT, 32'h1);
        Forward_RT_M_Sel = 3'd2; #1;
        chk("sel2_data", MF_RT_M_OUT, 32'h1);
        read_word("w8_fwd", 32'h20, 32'hDEAD_BEEF);

        // lw does not write
        IRM = IR_LW; AOM = 32'h10; RTM = 32'hFFFF_FFFF; Forward_RT_M_Sel = 3'd0;
        #1;
        chk("lw_memwrite", {31'b0, MemWrite}, 32'h0);
        tick();
        chk("lw_dout", Dout, 32'h1234_5678);

        // Address wrap and ignored low bits land in word 0
        IRM = IR_SW; AOM = 32'h1003; RTM = 32'hA5A5_A5A5;
        tick();
        read_word("wrap_w0", 32'h0, 32'hA5A5_A5A5);
        read_word("wrap_w4_kept", 32'h10, 32'h1234_5678);

        // Same-word read during write
        IRM = IR_SW; AOM = 32'h10; RTM = 32'h0BAD_F00D;
        #1;
        chk("rdw_old", Dout, 32'h1234_5678);
        tick();
        chk("rdw_new", Dout, 32'h0BAD_F00D);

        // Reset with a pending sw: outputs stay combinational, write dropped
        Reset = 1'b0; IRM = IR_SW; AOM = 32'h10; RTM = 32'h7777_7777;
        #1;
        chk("rst_memwrite", {31'b0, MemWrite}, 32'h1);
        chk("rst_data", MF_RT_M_OUT, 32'h7777_7777);
        tick();
        Reset = 1'b1;
        read_word("rst_w4", 32'h10, 32'h0);
        read_word("rst_w0", 32'h0, 32'h0);
        read_word("rst_w8", 32'h20, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have port Clk, input, 1, rising-edge clock.
REQ-003 SHALL have port Reset, input, 1; reset Reset, synchronous, active-low; clock Clk.
REQ-004 SHALL have port IRM, input, 32, M-stage instruction word.
REQ-005 SHALL have port PC4M, input, 32, M-stage PC+4; used only for the write trace.
REQ-006 SHALL have port AOM, input, 32, ALU result; this is the byte address.
REQ-007 SHALL have port RTM, input, 32, pipelined rt register value.
REQ-008 SHALL have port MUX_RF_WD_OUT, input, 32, W-stage write-back data used for forwarding.
REQ-009 SHALL have port Forward_RT_M_Sel, input, 3, store-data forward select.
REQ-010 SHALL have port MemWrite, output, 1, decoded store enable.
REQ-011 SHALL have port MF_RT_M_OUT, output, 32, forwarded store data.
REQ-012 SHALL have port Dout, output, 32, memory read data.

Function
REQ-013 SHALL drive MemWrite=1 combinationally iff IRM[31:26]==6'b101011 (sw); every other opcode gives 0, including IRM=0 (nop).
REQ-014 SHALL drive MF_RT_M_OUT combinationally: select 3'd1 gives MUX_RF_WD_OUT; select 3'd0 and every other code (2..7) gives RTM.
REQ-015 SHALL use AOM[ADDR_W+1:2] as word index; SHALL ignore AOM[1:0] and the upper bits, so addresses wrap modulo 4 KiB.
REQ-016 SHALL write MF_RT_M_OUT into the indexed word on the rising Clk edge when MemWrite=1 and Reset=1.
REQ-017 SHALL drive Dout combinationally (asynchronous read) from the indexed word.
REQ-018 SHALL return the pre-edge contents on Dout when reading and writing the same word in one cycle; the new value appears after the edge.
REQ-019 SHALL implement whole-word writes only; no byte or halfword enables.

Reset
REQ-020 SHALL clear every memory word to 0 on a rising Clk edge while Reset=0.
REQ-021 SHALL give reset priority over a simultaneous write; the write is dropped.
REQ-022 SHALL keep MemWrite and MF_RT_M_OUT purely combinational and unaffected by Reset.
REQ-023 SHALL initialise all memory words to 0 at time zero for simulation.

Configuration
REQ-024 SHALL print, when macro MEM_WRITE_TRACE_EN is defined, one line per performed write at that Clk edge, format "%d@%h: *%h <= %h": $time, PC4M-4, AOM, MF_RT_M_OUT.
REQ-025 SHALL print nothing when MEM_WRITE_TRACE_EN is undefined; functional behaviour SHALL be identical either way.

Structure
REQ-026 SHALL place the following in a shared package: opcode constant OP_SW=6'b101011, IR field ranges (opcode 31:26, funct 5:0), and forward-select codes FWD_RD=3'd0, FWD_WD=3'd1.
REQ-027 SHALL implement the memory array as a single sub-module data_mem (Clk, Reset, Addr, Din, We, Dout); opcode decode and forward mux SHALL stay inline.

Verification
REQ-028 SHALL cover: IRM=0xAC000000 (sw), AOM=0x10, RTM=0x12345678, sel=0, edge -> word 4 holds 0x12345678, Dout=0x12345678.
REQ-029 SHALL cover: sel=1, MUX_RF_WD_OUT=0xDEADBEEF, RTM=0x1, sw to AOM=0x20 -> MF_RT_M_OUT=0xDEADBEEF and word 8 holds 0xDEADBEEF; sel=5 -> output is RTM.
REQ-030 SHALL cover: IRM=0x8C000000 (lw) at AOM=0x10 -> MemWrite=0, memory unchanged, Dout=0x12345678.
REQ-031 SHALL cover: sw to AOM=0x1003 with data 0xA5A5A5A5 -> word 0 written (wrap, low bits ignored).
REQ-032 SHALL cover: Reset=0 for one edge while a sw is present -> all words read 0 afterwards, write dropped.
REQ-033 SHALL cover: same-word read during write -> Dout shows old value before the edge and new value after it; with MEM_WRITE_TRACE_EN defined, exactly one trace line per write.
